// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit                                                                  |
// | Instruction fetch: next-PC selection, credit-limited imem requests, 2-entry |
// | instruction buffer with redirect flush and in-flight response dropping.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter int BIT_WIDTH = 32,
  parameter int DEPTH     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] pc_current,
  output logic [BIT_WIDTH-1:0] pc_next,
  input  logic                 redirect_valid,
  input  logic [BIT_WIDTH-1:0] redirect_target,
  output logic                 imem_req,
  output logic [BIT_WIDTH-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [BIT_WIDTH-1:0] imem_rdata,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [BIT_WIDTH-1:0] if_instr,
  output logic [BIT_WIDTH-1:0] if_pc
);

  localparam logic [2:0] C_DEPTH = 3'(DEPTH);

  logic [1:0]           r_inflight;
  logic [1:0]           r_drop;
  logic [1:0]           r_count;
  logic [BIT_WIDTH-1:0] r_aq [2];
  logic                 r_aq_wr;
  logic                 r_aq_rd;
  logic [BIT_WIDTH-1:0] r_bi [2];
  logic [BIT_WIDTH-1:0] r_bp [2];
  logic                 r_b_wr;
  logic                 r_b_rd;

  logic [2:0]           w_used;
  logic                 w_fire;
  logic                 w_rv;
  logic                 w_push;
  logic                 w_pop;
  logic [BIT_WIDTH-1:0] w_target;

  assign w_used    = {1'b0, r_inflight} + {1'b0, r_count};
  assign imem_req  = !reset && !redirect_valid && (w_used < C_DEPTH);
  assign imem_addr = pc_current;
  assign w_fire    = imem_req && imem_gnt;
  // A response with nothing outstanding is ignored so the counters never wrap.
  assign w_rv      = imem_rvalid && (r_inflight != 2'd0);
  assign w_push    = w_rv && (r_drop == 2'd0) && !redirect_valid;
  assign if_valid  = !reset && (r_count != 2'd0) && !redirect_valid;
  assign w_pop     = if_valid && if_ready;
  assign if_instr  = r_bi[r_b_rd];
  assign if_pc     = r_bp[r_b_rd];
  assign w_target  = redirect_target & ~BIT_WIDTH'(3);

  always_comb begin
    pc_next = pc_current;
    if (reset)               pc_next = pc_current;
    else if (redirect_valid) pc_next = w_target;
    else if (w_fire)         pc_next = pc_current + BIT_WIDTH'(4);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= 2'd0;
      r_drop     <= 2'd0;
      r_count    <= 2'd0;
      r_aq_wr    <= 1'b0;
      r_aq_rd    <= 1'b0;
      r_b_wr     <= 1'b0;
      r_b_rd     <= 1'b0;
    end else begin
      if (w_fire) begin
        r_aq[r_aq_wr] <= pc_current;
        r_aq_wr       <= ~r_aq_wr;
      end
      if (w_rv) r_aq_rd <= ~r_aq_rd;
      r_inflight <= r_inflight + {1'b0, w_fire} - {1'b0, w_rv};
      if (redirect_valid) begin
        // Every response still owed after this edge belongs to the old path.
        r_drop  <= r_inflight + {1'b0, w_fire} - {1'b0, w_rv};
        r_count <= 2'd0;
        r_b_wr  <= 1'b0;
        r_b_rd  <= 1'b0;
      end else begin
        if (w_rv && (r_drop != 2'd0)) r_drop <= r_drop - 2'd1;
        if (w_push) begin
          r_bi[r_b_wr] <= imem_rdata;
          r_bp[r_b_wr] <= r_aq[r_aq_rd];
          r_b_wr       <= ~r_b_wr;
        end
        if (w_pop) r_b_rd <= ~r_b_rd;
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  a_rvalid_outstanding: assert property (@(posedge clock) disable iff (reset)
    imem_rvalid |-> (r_inflight != 2'd0));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_unit                                                               |
// | Randomized bench with a queue-based reference model and directed pins.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_current;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  always #5 clock = ~clock;

  fetch_unit #(.BIT_WIDTH(32), .DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .pc_current(pc_current), .pc_next(pc_next),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  typedef struct {logic [31:0] addr; bit stale;}        out_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} ins_t;
  typedef struct {logic [31:0] addr; int due;}          mem_t;

  out_t        m_out[$];
  ins_t        m_buf[$];
  mem_t        mq[$];
  logic [31:0] m_pc;
  int          cyc;
  int          last_due;
  int          n_chk;
  int          n_fail;

  bit          drv_reset;
  bit          drv_redir;
  bit          drv_ready;
  logic [31:0] drv_tgt;
  int unsigned gnt_pct;
  int          lat;

  logic [31:0] obs_pc[$];
  logic [31:0] obs_instr[$];
  int          obs_cyc[$];
  logic [31:0] s_pc_next;
  logic [31:0] s_addr;
  logic        s_req;
  logic        s_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] opc(input int i);
    return (i < obs_pc.size()) ? obs_pc[i] : 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] oins(input int i);
    return (i < obs_instr.size()) ? obs_instr[i] : 32'hDEADBEEF;
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step();
    logic        e_req, e_fire, e_valid, rv;
    logic [31:0] e_next, tgt;
    out_t        o;
    int          d;
    reset           = drv_reset;
    redirect_valid  = drv_redir;
    redirect_target = drv_tgt;
    if_ready        = drv_ready;
    pc_current      = m_pc;
    imem_gnt        = ($urandom_range(99) < gnt_pct);
    rv              = !drv_reset && (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rvalid     = rv;
    imem_rdata      = rv ? (mq[0].addr ^ 32'hA5A5A5A5) : $urandom;
    #2;
    tgt     = drv_tgt & 32'hFFFFFFFC;
    e_req   = !drv_reset && !drv_redir && ((m_out.size() + m_buf.size()) < 2);
    e_fire  = e_req && imem_gnt;
    e_valid = !drv_reset && !drv_redir && (m_buf.size() > 0);
    e_next  = drv_reset ? m_pc : drv_redir ? tgt : e_fire ? m_pc + 32'd4 : m_pc;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_next", pc_next, e_next);
    chk("if_valid", 32'(if_valid), 32'(e_valid));
    if (e_valid) begin
      chk("if_instr", if_instr, m_buf[0].instr);
      chk("if_pc", if_pc, m_buf[0].pc);
    end
    s_pc_next = pc_next;
    s_addr    = imem_addr;
    s_req     = imem_req;
    s_valid   = if_valid;
    if (if_valid === 1'b1 && drv_ready) begin
      obs_pc.push_back(if_pc);
      obs_instr.push_back(if_instr);
      obs_cyc.push_back(cyc);
    end
    if (drv_reset) begin
      m_out.delete();
      m_buf.delete();
      mq.delete();
      m_pc     = 32'd0;
      last_due = cyc;
    end else begin
      if (e_valid && drv_ready) m_buf.delete(0);
      if (rv) begin
        o = m_out.pop_front();
        mq.delete(0);
        if (!o.stale && !drv_redir) m_buf.push_back('{imem_rdata, o.addr});
      end
      if (e_fire) begin
        d = cyc + lat;
        if (last_due + 1 > d) d = last_due + 1;
        last_due = d;
        m_out.push_back('{m_pc, 1'b0});
        mq.push_back('{m_pc, d});
      end
      if (drv_redir) begin
        foreach (m_out[i]) m_out[i].stale = 1'b1;
        m_buf.delete();
      end
      m_pc = e_next;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    drv_reset = 1'b1;
    drv_redir = 1'b0;
    repeat (2) begin
      step();
      chk("req_in_reset", 32'(s_req), 32'd0);
    end
    drv_reset = 1'b0;
    obs_pc.delete();
    obs_instr.delete();
    obs_cyc.delete();
  endtask

  initial begin
    int start;
    n_chk = 0; n_fail = 0; cyc = 0; last_due = 0; m_pc = 32'd0;
    drv_reset = 1'b1; drv_redir = 1'b0; drv_ready = 1'b1; drv_tgt = 32'd0;
    gnt_pct = 100; lat = 1;
    @(posedge clock);
    #1;

    // 1-cycle memory, decode always ready: steady 2-per-3 stream.
    do_reset();
    start = cyc;
    repeat (32) step();
    chk("p1_count", 32'(obs_pc.size()), 32'd20);
    chk("p1_first_cycle", 32'(obs_cyc.size() > 0 ? obs_cyc[0] - start : -1), 32'd2);
    chk("p1_pc0", opc(0), 32'h0);
    chk("p1_pc1", opc(1), 32'h4);
    chk("p1_pc2", opc(2), 32'h8);
    chk("p1_pc3", opc(3), 32'hC);
    chk("p1_in0", oins(0), 32'hA5A5A5A5);
    chk("p1_in1", oins(1), 32'hA5A5A5A1);
    chk("p1_in2", oins(2), 32'hA5A5A5AD);
    chk("p1_in3", oins(3), 32'hA5A5A5A9);

    // Decode stalled: buffer fills, requests stop, PC parks at 0x8.
    do_reset();
    drv_ready = 1'b0;
    repeat (10) step();
    chk("p2_req", 32'(s_req), 32'd0);
    chk("p2_pc_next", s_pc_next, 32'h8);
    chk("p2_none", 32'(obs_pc.size()), 32'd0);
    drv_ready = 1'b1;
    repeat (4) step();
    chk("p2_pc0", opc(0), 32'h0);
    chk("p2_pc1", opc(1), 32'h4);

    // 3-cycle memory, redirect with two fetches in flight.
    do_reset();
    lat = 3;
    repeat (2) step();
    drv_redir = 1'b1; drv_tgt = 32'h103;
    step();
    chk("p3_pc_next", s_pc_next, 32'h100);
    chk("p3_valid", 32'(s_valid), 32'd0);
    drv_redir = 1'b0;
    repeat (12) step();
    chk("p3_pc0", opc(0), 32'h100);
    chk("p3_in0", oins(0), 32'hA5A5A4A5);

    // Redirect coinciding with rvalid and a pending pop.
    do_reset();
    lat = 1;
    repeat (2) step();
    drv_redir = 1'b1; drv_tgt = 32'h200;
    step();
    chk("p4_valid", 32'(s_valid), 32'd0);
    chk("p4_none", 32'(obs_pc.size()), 32'd0);
    drv_redir = 1'b0;
    repeat (8) step();
    chk("p4_pc0", opc(0), 32'h200);

    // Fetch at the top of the address space wraps to zero.
    do_reset();
    drv_redir = 1'b1; drv_tgt = 32'hFFFFFFFF;
    step();
    drv_redir = 1'b0;
    step();
    chk("p5_wrap", s_pc_next, 32'h0);
    repeat (6) step();
    chk("p5_pc0", opc(0), 32'hFFFFFFFC);
    chk("p5_pc1", opc(1), 32'h0);

    // Grant withheld: request and address hold.
    do_reset();
    gnt_pct = 0;
    repeat (5) begin
      step();
      chk("p6_req", 32'(s_req), 32'd1);
      chk("p6_addr", s_addr, 32'h0);
      chk("p6_hold", s_pc_next, 32'h0);
    end
    gnt_pct = 100;
    step();
    chk("p6_fire", s_pc_next, 32'h4);

    // Randomized traffic.
    do_reset();
    for (int seg = 0; seg < 20; seg++) begin
      lat     = $urandom_range(4, 1);
      gnt_pct = $urandom_range(100, 20);
      for (int i = 0; i < 200; i++) begin
        drv_reset = ($urandom_range(499) == 0);
        drv_redir = ($urandom_range(15) == 0);
        drv_tgt   = ($urandom_range(7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15))) : $urandom;
        drv_ready = ($urandom_range(3) != 0);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
